// File: rtl/sfx_tone_seq.sv
// Sound-effect tone sequencer: emits the at_max pitch strobe for the DAC sample counter.
// Optional mute input is enabled by defining SFX_MUTE_EN.
module sfx_tone_seq #(
    parameter int unsigned DIV_W    = 12,
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       play_eat,
    input  logic       play_crash,
`ifdef SFX_MUTE_EN
    input  logic       mute,
`endif
    output logic       at_max,
    output logic       busy,
    output logic [1:0] sfx_id,
    output logic [1:0] note_idx
);

    localparam int unsigned       TICK_W    = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [1:0]        SFX_NONE  = 2'd0;
    localparam logic [1:0]        SFX_EAT   = 2'd1;
    localparam logic [1:0]        SFX_CRASH = 2'd2;

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    state_t            state_q, state_d;
    logic [1:0]        sfx_q, sfx_d;
    logic [1:0]        note_q, note_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [2:0]        dur_q, dur_d;
    logic              eat_prev_q, crash_prev_q;

    logic              start_eat, start_crash, play_on, last_note;
    logic [DIV_W-1:0]  cur_max;
    logic [2:0]        cur_dur;

    // Fixed note table: divider max per (effect, note)
    function automatic logic [DIV_W-1:0] note_max(input logic [1:0] sfx, input logic [1:0] idx);
        logic [DIV_W-1:0] m;
        m = DIV_W'(200);
        if (sfx == SFX_CRASH) begin
            case (idx)
                2'd0:    m = DIV_W'(400);
                2'd1:    m = DIV_W'(500);
                2'd2:    m = DIV_W'(600);
                default: m = DIV_W'(800);
            endcase
        end else begin
            m = (idx == 2'd0) ? DIV_W'(200) : DIV_W'(150);
        end
        return m;
    endfunction

    assign cur_max   = note_max(sfx_q, note_q);
    assign cur_dur   = (sfx_q == SFX_CRASH) ? 3'd4 : 3'd3;
    assign last_note = (sfx_q == SFX_CRASH) ? (note_q == 2'd3) : (note_q == 2'd1);

    // Triggers act on their first high cycle only; crash preempts eat but never itself
    assign start_crash = play_crash & ~crash_prev_q & ~((state_q != IDLE) && (sfx_q == SFX_CRASH));
    assign start_eat   = play_eat & ~eat_prev_q & (state_q == IDLE);

    assign play_on = (state_q == PLAY) && (div_q == cur_max);
`ifdef SFX_MUTE_EN
    assign at_max  = play_on & ~mute;
`else
    assign at_max  = play_on;
`endif

    assign busy     = (state_q != IDLE);
    assign sfx_id   = sfx_q;
    assign note_idx = note_q;

    always_ff @(posedge clk) begin
        eat_prev_q   <= play_eat;
        crash_prev_q <= play_crash;
        if (rst) begin
            state_q <= IDLE;
            sfx_q   <= SFX_NONE;
            note_q  <= 2'd0;
            div_q   <= '0;
            tick_q  <= '0;
            dur_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            sfx_q   <= sfx_d;
            note_q  <= note_d;
            div_q   <= div_d;
            tick_q  <= tick_d;
            dur_q   <= dur_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sfx_d   = sfx_q;
        note_d  = note_q;
        div_d   = div_q;
        tick_d  = tick_q;
        dur_d   = dur_q;
        case (state_q)
            IDLE: begin
            end
            PLAY: begin
                div_d = (div_q == cur_max) ? '0 : div_q + DIV_W'(1);
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    if (dur_q == cur_dur - 3'd1) begin
                        div_d = '0;
                        dur_d = 3'd0;
                        if (last_note) begin
                            state_d = IDLE;
                            sfx_d   = SFX_NONE;
                            note_d  = 2'd0;
                        end else begin
                            state_d = GAP;
                        end
                    end else begin
                        dur_d = dur_q + 3'd1;
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            GAP: begin
                div_d = '0;
                if (tick_q == TICK_LAST) begin
                    state_d = PLAY;
                    note_d  = note_q + 2'd1;
                    tick_d  = '0;
                    dur_d   = 3'd0;
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (start_crash) begin
            state_d = PLAY;
            sfx_d   = SFX_CRASH;
            note_d  = 2'd0;
            div_d   = '0;
            tick_d  = '0;
            dur_d   = 3'd0;
        end else if (start_eat) begin
            state_d = PLAY;
            sfx_d   = SFX_EAT;
            note_d  = 2'd0;
            div_d   = '0;
            tick_d  = '0;
            dur_d   = 3'd0;
        end
    end

endmodule

// File: tb/tb_sfx_tone_seq.sv
// Testbench for sfx_tone_seq with TICK_DIV=1000: vector table plus directed effect sequences.
module tb_sfx_tone_seq;

    logic       clk;
    logic       rst;
    logic       play_eat;
    logic       play_crash;
`ifdef SFX_MUTE_EN
    logic       mute;
`endif
    logic       at_max;
    logic       busy;
    logic [1:0] sfx_id;
    logic [1:0] note_idx;

    int checks;
    int failures;

    sfx_tone_seq #(.DIV_W(12), .TICK_DIV(1000)) dut (
        .clk        (clk),
        .rst        (rst),
        .play_eat   (play_eat),
        .play_crash (play_crash),
`ifdef SFX_MUTE_EN
        .mute       (mute),
`endif
        .at_max     (at_max),
        .busy       (busy),
        .sfx_id     (sfx_id),
        .note_idx   (note_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       eat;
        logic       crash;
        logic       e_busy;
        logic       e_at;
        logic [1:0] e_sfx;
        logic [1:0] e_note;
    } vec_t;

    vec_t vecs[13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        play_eat   = 1'b0;
        play_crash = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // Run n cycles from the current one, counting strobes, first offset, spacing and busy cycles
    task automatic run_count(input int n, input int period, output int cnt, output int first,
                             output int busy_cnt, output int per_ok);
        int last;
        cnt = 0; first = -1; busy_cnt = 0; per_ok = 1; last = -1;
        for (int i = 0; i < n; i++) begin
            if (at_max) begin
                if (cnt == 0) first = i;
                else if (i - last != period) per_ok = 0;
                last = i;
                cnt++;
            end
            if (busy) busy_cnt++;
            step();
        end
    endtask

    initial begin
        int cnt, first, bcnt, pok, total_busy;
        int cmax[4];
        int ccnt[4];
        cmax = '{400, 500, 600, 800};
        ccnt = '{9, 7, 6, 4};
        checks = 0;
        failures = 0;
        clk = 1'b0;
        rst = 1'b1;
        play_eat = 1'b0;
        play_crash = 1'b0;
`ifdef SFX_MUTE_EN
        mute = 1'b0;
`endif

        // rst eat crash | busy at_max sfx note
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 2'd0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 2'd0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 2'd0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 2'd0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 2'd0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 2'd0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};

        for (int i = 0; i < 13; i++) begin
            rst        = vecs[i].rst;
            play_eat   = vecs[i].eat;
            play_crash = vecs[i].crash;
            step();
            check($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].e_busy));
            check($sformatf("vec%0d_at_max", i), int'(at_max), int'(vecs[i].e_at));
            check($sformatf("vec%0d_sfx", i), int'(sfx_id), int'(vecs[i].e_sfx));
            check($sformatf("vec%0d_note", i), int'(note_idx), int'(vecs[i].e_note));
        end

        // Full eat effect
        do_reset();
        play_eat = 1'b1;
        step();
        play_eat = 1'b0;
        check("eat_start_busy", int'(busy), 1);
        check("eat_start_sfx", int'(sfx_id), 1);
        run_count(3000, 201, cnt, first, bcnt, pok);
        check("eat_n0_cnt", cnt, 14);
        check("eat_n0_first", first, 200);
        check("eat_n0_period", pok, 1);
        check("eat_gap_note", int'(note_idx), 0);
        run_count(1000, 1, cnt, first, bcnt, pok);
        check("eat_gap_pulses", cnt, 0);
        check("eat_gap_busy", bcnt, 1000);
        check("eat_n1_note", int'(note_idx), 1);
        run_count(3000, 151, cnt, first, bcnt, pok);
        check("eat_n1_cnt", cnt, 19);
        check("eat_n1_first", first, 150);
        check("eat_n1_period", pok, 1);
        check("eat_n1_busy", bcnt, 3000);
        check("eat_end_busy", int'(busy), 0);
        check("eat_end_sfx", int'(sfx_id), 0);
        check("eat_end_note", int'(note_idx), 0);

        // Full crash effect
        do_reset();
        play_crash = 1'b1;
        step();
        play_crash = 1'b0;
        total_busy = 0;
        for (int n = 0; n < 4; n++) begin
            check($sformatf("crash_n%0d_note", n), int'(note_idx), n);
            check($sformatf("crash_n%0d_sfx", n), int'(sfx_id), 2);
            run_count(4000, cmax[n] + 1, cnt, first, bcnt, pok);
            total_busy += bcnt;
            check($sformatf("crash_n%0d_cnt", n), cnt, ccnt[n]);
            check($sformatf("crash_n%0d_first", n), first, cmax[n]);
            check($sformatf("crash_n%0d_period", n), pok, 1);
            if (n < 3) begin
                run_count(1000, 1, cnt, first, bcnt, pok);
                total_busy += bcnt;
                check($sformatf("crash_gap%0d_pulses", n), cnt, 0);
            end
        end
        check("crash_total_busy", total_busy, 19000);
        check("crash_end_busy", int'(busy), 0);

        // Crash preempts eat 1500 cycles in
        do_reset();
        play_eat = 1'b1;
        step();
        play_eat = 1'b0;
        run_count(1499, 201, cnt, first, bcnt, pok);
        play_crash = 1'b1;
        step();
        play_crash = 1'b0;
        check("pre_sfx", int'(sfx_id), 2);
        check("pre_note", int'(note_idx), 0);
        run_count(401, 401, cnt, first, bcnt, pok);
        check("pre_cnt", cnt, 1);
        check("pre_first", first, 400);
        play_eat = 1'b1;
        step();
        play_eat = 1'b0;
        check("pre_eat_ignored", int'(sfx_id), 2);

        // Simultaneous triggers and crash retrigger mid-note
        do_reset();
        play_eat = 1'b1;
        play_crash = 1'b1;
        step();
        play_eat = 1'b0;
        play_crash = 1'b0;
        check("sim_sfx", int'(sfx_id), 2);
        run_count(1000, 401, cnt, first, bcnt, pok);
        check("sim_cnt_a", cnt, 2);
        check("sim_first_a", first, 400);
        play_crash = 1'b1;
        step();
        play_crash = 1'b0;
        check("sim_retrig_note", int'(note_idx), 0);
        run_count(2999, 401, cnt, first, bcnt, pok);
        check("sim_cnt_b", cnt, 7);
        check("sim_first_b", first, 201);
        check("sim_period_b", pok, 1);
        check("sim_gap_busy", int'(busy), 1);
        check("sim_gap_note", int'(note_idx), 0);

`ifdef SFX_MUTE_EN
        // Mute during eat note 0 offsets 300..700
        do_reset();
        play_eat = 1'b1;
        step();
        play_eat = 1'b0;
        begin
            int mcnt;
            int saw803;
            int saw_muted;
            mcnt = 0; saw803 = 0; saw_muted = 0;
            for (int i = 0; i < 3000; i++) begin
                mute = (i >= 300 && i <= 700);
                #1;
                if (at_max) begin
                    mcnt++;
                    if (i == 803) saw803 = 1;
                    if (i == 401 || i == 602) saw_muted = 1;
                end
                @(posedge clk);
                #1;
            end
            mute = 1'b0;
            check("mute_cnt", mcnt, 12);
            check("mute_803", saw803, 1);
            check("mute_gone", saw_muted, 0);
        end
        run_count(4000, 151, cnt, first, bcnt, pok);
        check("mute_busy_tail", bcnt, 4000);
        check("mute_end_busy", int'(busy), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sfx_tone_seq.md
Name: sfx_tone_seq

Overview:
- Sound-effect sequencer that sits directly upstream of the 8-bit DAC sample counter.
- Produces the single-cycle at_max strobe that advances that counter, so the strobe rate sets the audible pitch.
- Plays short fixed note sequences (snake "eat", snake "crash") when game logic pulses a trigger.
- Drives no pulses when idle or between notes, so the DAC counter holds its value.

Parameters:
- DIV_W, 12: width of the pitch divider counter; every table max value fits in it.
- TICK_DIV, 50000: clock cycles per duration tick, which is 1 ms at 50 MHz. Must be ≥2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- play_eat  in  1  single-cycle trigger for the eat effect
- play_crash  in  1  single-cycle trigger for the crash effect
- at_max  out  1  single-cycle pitch strobe to the DAC counter
- busy  out  1  high while an effect is playing, including gaps
- sfx_id  out  2  current effect: 0 none, 1 eat, 2 crash
- note_idx  out  2  index of the current note within the effect

Behaviour:
- Reset: on rst sampled high at a rising edge, the state goes to IDLE and all counters clear. at_max, busy, sfx_id and note_idx are all 0. rst has priority over triggers.
- Note table, fixed, as {divider max, duration in ticks}:
  - eat: {200,3}, {150,3}
  - crash: {400,4}, {500,4}, {600,4}, {800,4}
- States: IDLE, PLAY, GAP.
- IDLE:
  - Trigger seen at edge k gives state PLAY from cycle k+1.
  - At k+1: busy=1, sfx_id is set, note_idx=0, div_cnt=0, tick_cnt=0, dur_cnt=0.
- PLAY:
  - div_cnt counts 0..max, then wraps to 0.
  - at_max=1 exactly in the cycles where div_cnt==max, so the pulse period is max+1 cycles and the first pulse comes max cycles after note start.
  - tick_cnt counts 0..TICK_DIV-1. dur_cnt increments when tick_cnt wraps.
  - A note lasts exactly dur*TICK_DIV cycles.
  - At note end, if it is not the last note, go to GAP. If it is the last note, go to IDLE: busy, sfx_id and note_idx return to 0 the next cycle.
- GAP:
  - Lasts exactly TICK_DIV cycles, with at_max held at 0.
  - Then note_idx increments and the state returns to PLAY with div_cnt, tick_cnt and dur_cnt all cleared.
- at_max is combinational from state and div_cnt only, never from the triggers. It is never high in IDLE or GAP.
- Trigger priority:
  - play_crash and play_eat asserted in the same cycle: crash wins.
  - play_crash while eat is busy (PLAY or GAP): preempts eat and restarts at crash note 0 next cycle, with all counters cleared.
  - play_crash while crash is busy: ignored.
  - play_eat while busy with any effect: ignored.
- A trigger held high for several cycles behaves as one trigger at its first cycle, plus the rules above for the remaining cycles.
- Counter widths:
  - div_cnt is DIV_W bits.
  - tick_cnt is sized for TICK_DIV-1.
  - dur_cnt is 3 bits.
  - No counter ever overflows: all wraps are explicit compares.

Optional Feature:
- Macro: SFX_MUTE_EN.
- Defined: adds input port mute (1 bit), placed after play_crash.
  - While mute=1, at_max is forced to 0.
  - Sequencing, timing, busy, sfx_id and note_idx are unaffected, so unmuting mid-note resumes pulses in phase with div_cnt.
- Undefined: no mute port; at_max behaves as specified above.

Test Plan (TICK_DIV=1000 unless noted):
- Reset: assert rst for 2 cycles with play_crash=1 → busy=0, at_max=0, sfx_id=0, note_idx=0 throughout and after release.
- Eat effect: play_eat pulse at edge k.
  - busy=1 from k+1.
  - Note 0 gives 14 at_max pulses, 201 cycles apart, first at k+1+200.
  - Gap of 1000 cycles with 0 pulses.
  - Note 1 gives 19 pulses, 151 cycles apart.
  - busy=0 exactly 7000 cycles after k+1.
- Crash effect: play_crash pulse.
  - Pulse counts per note are 9, 7, 6, 4 (periods 401/501/601/801 over 4000 cycles).
  - note_idx steps 0→1→2→3.
  - Total busy time is 19000 cycles.
- Preempt: play_eat, then play_crash 1500 cycles later → next cycle sfx_id=2, note_idx=0, and the next at_max comes 400 cycles later. A play_eat issued during the crash is ignored (sfx_id stays 2).
- Simultaneous: play_eat=play_crash=1 in the same cycle → sfx_id=2. Retriggering play_crash mid-crash does not alter note_idx or pulse timing.
- SFX_MUTE_EN: during eat note 0, mute=1 for cycles 300..700 of the note → the pulses at offsets 401 and 602 are missing. The pulse at 803 is present, and busy timing is unchanged.
